// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns one at a time, debounces press and
// release on the synchronized rows, and emits a hex key code with a valid strobe.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

  // Nibble {row, col} holds the legend printed on that key; entry 0 is row0/col0.
  localparam logic [63:0] KEY_TABLE = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync_q, rs_q;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       pat_q, pat_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [1:0]       low_row;

  always_comb begin
    if      (!rs_q[0]) low_row = 2'd0;
    else if (!rs_q[1]) low_row = 2'd1;
    else if (!rs_q[2]) low_row = 2'd2;
    else               low_row = 2'd3;
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pat_d       = pat_q;
    div_d       = div_q;
    db_d        = db_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    unique case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          if (rs_q == 4'hF) begin
            col_d = col_q + 2'd1;
            div_d = '0;
          end else begin
            row_d   = low_row;
            pat_d   = rs_q;
            db_d    = '0;
            state_d = DEBOUNCE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs_q != pat_q) begin
          col_d   = col_q + 2'd1;
          div_d   = '0;
          state_d = SCAN;
        end else if (db_q == DB_LAST) begin
          key_code_d  = KEY_TABLE[{row_q, col_q, 2'b00} +: 4];
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = PRESSED;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      PRESSED: begin
        // Only the accepted row is watched, so extra keys cannot start a new press.
        if (rs_q[row_q]) begin
          db_d    = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!rs_q[row_q]) begin
          state_d = PRESSED;
        end else if (db_q == DB_LAST) begin
          key_held_d = 1'b0;
          col_d      = col_q + 2'd1;
          div_d      = '0;
          state_d    = SCAN;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      sync_q      <= 4'hF;
      rs_q        <= 4'hF;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      pat_q       <= 4'hF;
      div_q       <= '0;
      db_q        <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= rows_n;
      rs_q        <= sync_q;
      col_q       <= col_d;
      row_q       <= row_d;
      pat_q       <= pat_d;
      div_q       <= div_d;
      db_q        <= db_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the keyboard encoder / register-bank write path.
- Drives a 4x4 matrix keypad column by column and reads the rows.
- Debounces the press and the release, and emits a hex key code with a one-cycle valid strobe.
- key_code feeds the register-bank data input (zero-extended to 8 bits); key_valid is the write-enable source.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before rows are sampled (min 2)
DEBOUNCE_CNT, 20000, consecutive stable cycles required to accept a press or a release (min 2)

Ports:
clk       input   1  system clock, all logic on rising edge
reset     input   1  synchronous, active-high; sampled on rising clk
rows_n    input   4  keypad row lines, active-low, asynchronous to clk
col_n     output  4  keypad column drive, one-hot active-low
key_code  output  4  hex code of the last accepted key
key_valid output  1  one-cycle pulse when a new key is accepted
key_held  output  1  high from acceptance until the debounced release completes

Behaviour:
- rows_n passes through a 2-flop synchronizer (reset value 4'b1111). All decisions use the synchronized value rs.
- Reset values: col_n=4'b1110, key_code=4'h0, key_valid=0, key_held=0, state=SCAN. All counters and the synchronizer are cleared.
- Reset asserted in any state returns the block to these values on the next edge. No key_valid is produced by reset.
- Key map (row r, column c): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
- Column c is active when col_n[c]=0.
- SCAN:
  - div counts 0..SCAN_DIV-1 with the current column driven.
  - At div=SCAN_DIV-1, sample rs.
  - If rs==4'b1111: rotate to the next column (0->1->2->3->0) and clear div.
  - Otherwise: latch the column index and row index (the lowest-index low row wins if several are low), latch the pattern rs, clear db, go to DEBOUNCE. The column is held.
- DEBOUNCE:
  - If rs != latched pattern on any cycle: abandon, rotate to the next column, clear div, go to SCAN.
  - Otherwise db increments. When db reaches DEBOUNCE_CNT-1:
    - next edge: state=PRESSED
    - key_code = map(row, col)
    - key_valid=1 for exactly that one cycle
    - key_held=1
- PRESSED:
  - Column stays held.
  - Only the latched row bit is watched; other rows changing are ignored (no second key, no rollover).
  - When the latched row bit reads 1: clear db, go to RELEASE.
- RELEASE:
  - db increments while the latched row bit is 1.
  - If the bit returns to 0 before DEBOUNCE_CNT cycles: back to PRESSED; no new key_valid, key_held stays 1.
  - At db=DEBOUNCE_CNT-1: key_held=0, rotate to the next column, clear div, go to SCAN.
- key_code retains its value after release until the next accepted key.
- Press latency: a stable press on column c is accepted at most 2 + 4*SCAN_DIV + DEBOUNCE_CNT + 1 cycles after the rows_n change.
- Counter widths: div is $clog2(SCAN_DIV) bits; db is $clog2(DEBOUNCE_CNT) bits. No overflow is possible because of the terminal compares.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=8.
1. Reset then idle 64 cycles with rows_n=4'hF -> col_n cycles 1110, 1101, 1011, 0111 with each value held 4 cycles; key_valid never asserts; key_code=0.
2. Hold row1 low only while col_n=1011 (row1/col2), held stable -> exactly one key_valid pulse with key_code=4'h6, within 2+16+8+1 cycles; key_held=1; col_n frozen at 1011.
3. Bounce: toggle row0/col0 every 3 cycles for 30 cycles, then hold low -> no key_valid during bouncing; a single pulse with key_code=4'h1 after the stable hold.
4. Release glitch: after accepting key 0 (row3/col1), release for 5 cycles, press again, then release stable for 12 cycles -> no second key_valid; key_held falls exactly 8 cycles into the stable release; scanning resumes at col_n=1011.
5. Two rows low (row0 and row2 on col3) -> key_code=4'hA (lowest row wins); additionally pressing row1 during PRESSED produces no pulse.
6. Assert reset for 1 cycle during DEBOUNCE and during PRESSED -> next cycle col_n=1110, key_held=0, key_valid=0, key_code=0.
